// File: rtl/rr_dff_arbiter.sv
// Round-robin arbiter that shares one DATA_W-bit register among N_REQ requesters.
// Every write can optionally be followed by a fixed number of locked (HOLD) cycles.
module rr_dff_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int HOLD_CYC = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_W-1:0]    wdata,
    output logic [N_REQ-1:0]           gnt,
    output logic [DATA_W-1:0]          q,
    output logic                       q_valid,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy
);

    localparam int OW = $clog2(N_REQ);
    localparam int CW = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_r;
    logic [OW-1:0]   ptr_r;
    logic [CW-1:0]   cnt_r;

    logic [N_REQ-1:0] eff_s;
    logic [OW-1:0]    win_s;
    logic             found_s;
    logic [OW-1:0]    nxt_ptr_s;

    // Last cycle's grantee is masked so a still-asserted req is not written twice.
    assign eff_s = req & ~gnt;

    // Pick the first eligible requester at or after ptr; scanning downwards
    // lets the smallest rotated offset overwrite any later candidate.
    always_comb begin
        win_s   = '0;
        found_s = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr_r) + k) % N_REQ;
            if (eff_s[idx]) begin
                win_s   = idx[OW-1:0];
                found_s = 1'b1;
            end else begin
                win_s   = win_s;
                found_s = found_s;
            end
        end
    end

    // Pointer advances past the winner, wrapping from N_REQ-1 to 0.
    always_comb begin
        if (int'(win_s) == N_REQ - 1) begin
            nxt_ptr_s = '0;
        end else begin
            nxt_ptr_s = win_s + OW'(1);
        end
    end

    // Arbitration state machine with registered grant, data and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            cnt_r   <= '0;
            gnt     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            owner   <= '0;
            busy    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        q       <= wdata[int'(win_s)*DATA_W +: DATA_W];
                        owner   <= win_s;
                        q_valid <= 1'b1;
                        gnt     <= N_REQ'(1) << win_s;
                        ptr_r   <= nxt_ptr_s;
                        if (HOLD_CYC > 0) begin
                            state_r <= HOLD;
                            cnt_r   <= CW'(HOLD_CYC - 1);
                            busy    <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        gnt <= '0;
                    end
                end
                HOLD: begin
                    gnt <= '0;
                    if (cnt_r == CW'(0)) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt     <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
